// File: rtl/lcd_fmt_pkg.sv
// lcd_fmt_pkg: shared FSM states, ASCII constants and the digit-to-ASCII
// helper used by the LCD field formatter.
package lcd_fmt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    CONV,
    WRITE,
    COMMIT
  } fmt_state_t;

  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_STAR  = 8'h2A;

  function automatic logic [7:0] nib2ascii(input logic [3:0] d);
    logic [7:0] c;
    unique case (1'b1)
      (d < 4'd10): c = CH_ZERO + {4'd0, d};
      default:     c = CH_A + {4'd0, d} - 8'd10;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_field_fmt_if.sv
// lcd_field_fmt_if: request/value inputs and committed row outputs.
// master = status logic side, slave = formatter side.
interface lcd_field_fmt_if #(
  parameter int NUM_FIELDS = 4,
  parameter int VAL_W      = 16,
  parameter int ROW_CHARS  = 16
);
  logic                        refresh;
  logic                        auto_refresh;
  logic [NUM_FIELDS*VAL_W-1:0] values;
  logic [8*ROW_CHARS-1:0]      row_a;
  logic [8*ROW_CHARS-1:0]      row_b;
  logic                        busy;
  logic                        frame_done;

  modport master (
    output refresh, auto_refresh, values,
    input  row_a, row_b, busy, frame_done
  );

  modport slave (
    input  refresh, auto_refresh, values,
    output row_a, row_b, busy, frame_done
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: VAL_W-cycle double-dabble; start loads bin and does the
// first shift, done marks the last shift cycle, ovf = carry out of top digit.
module bin2bcd_seq #(
  parameter int VAL_W   = 16,
  parameter int DEC_MAX = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [VAL_W-1:0]     bin,
  output logic                 busy,
  output logic                 done,
  output logic [4*DEC_MAX-1:0] bcd,
  output logic                 ovf
);
  localparam int CW = $clog2(VAL_W + 1);

  logic [VAL_W-1:0]     sh;
  logic [CW-1:0]        cnt;
  logic [4*DEC_MAX-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int d = 0; d < DEC_MAX; d++) begin
      if (bcd[4*d +: 4] > 4'd4)
        adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  assign done = busy && (cnt == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      sh   <= '0;
      bcd  <= '0;
      ovf  <= 1'b0;
    end else if (start) begin
      // adjust on an all-zero register is a no-op, so shift straight in
      bcd  <= {{(4*DEC_MAX-1){1'b0}}, bin[VAL_W-1]};
      sh   <= bin << 1;
      cnt  <= CW'(VAL_W - 1);
      busy <= 1'b1;
      ovf  <= 1'b0;
    end else if (busy) begin
      bcd  <= {adj[4*DEC_MAX-2:0], sh[VAL_W-1]};
      ovf  <= ovf | adj[4*DEC_MAX-1];
      sh   <= sh << 1;
      cnt  <= cnt - CW'(1);
      busy <= (cnt != CW'(1));
    end
  end
endmodule

// File: rtl/lcd_field_fmt.sv
// lcd_field_fmt: formats NUM_FIELDS values into two LCD rows, one field
// per WRITE; clk/reset plain, all else on bus (refresh/values in, rows out).
module lcd_field_fmt
  import lcd_fmt_pkg::*;
#(
  parameter int NUM_FIELDS = 4,
  parameter int VAL_W      = 16,
  parameter int ROW_CHARS  = 16,
  parameter int DEC_MAX    = 5,
  parameter logic [NUM_FIELDS-1:0]   FIELD_ROW   = 4'b0110,
  parameter logic [4*NUM_FIELDS-1:0] FIELD_COL   = {4'd8, 4'd8, 4'd0, 4'd0},
  parameter logic [3*NUM_FIELDS-1:0] FIELD_DIG   = {3'd5, 3'd4, 3'd2, 3'd2},
  parameter logic [NUM_FIELDS-1:0]   FIELD_DEC   = 4'b1000,
  parameter logic [NUM_FIELDS-1:0]   FIELD_BLANK = 4'b1000,
  parameter logic [8*ROW_CHARS-1:0]  ROW_INIT    = "????????????????"
) (
  input logic             clk,
  input logic             reset,
  lcd_field_fmt_if.slave  bus
);
  localparam int HEXD = (VAL_W + 3) / 4;
  localparam int NDIG = (DEC_MAX > HEXD) ? DEC_MAX : HEXD;
  localparam int DW   = 4 * NDIG;
  localparam int IW   = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

  fmt_state_t state_q, state_d;

  logic [IW-1:0]               idx_q;
  logic [NUM_FIELDS*VAL_W-1:0] vals_q;
  logic [8*ROW_CHARS-1:0]      sh_a, sh_b;
  logic [8*ROW_CHARS-1:0]      row_a_q, row_b_q;
  logic                        pend_q, done_q;
  logic [DW-1:0]               hex_q;

  logic [VAL_W-1:0]     f_val;
  logic                 f_row, f_dec, f_blk;
  logic [3:0]           f_col;
  logic [2:0]           f_dig;
  logic                 last;

  logic                 bcd_start, bcd_busy, bcd_done, bcd_ovf;
  logic [4*DEC_MAX-1:0] bcd;

  logic [DW-1:0]          src;
  logic                   ovf;
  logic                   lead;
  logic [3:0]             d;
  logic [7:0]             ch;
  int                     k, col;
  logic [8*ROW_CHARS-1:0] wrow;

  assign f_val = vals_q[int'(idx_q)*VAL_W +: VAL_W];
  assign f_row = FIELD_ROW[idx_q];
  assign f_dec = FIELD_DEC[idx_q];
  assign f_blk = FIELD_BLANK[idx_q];
  assign f_col = FIELD_COL[4*int'(idx_q) +: 4];
  assign f_dig = FIELD_DIG[3*int'(idx_q) +: 3];
  assign last  = (int'(idx_q) == NUM_FIELDS - 1);

  assign bcd_start = (state_q == CONV) && f_dec && !bcd_busy;

  bin2bcd_seq #(
    .VAL_W   (VAL_W),
    .DEC_MAX (DEC_MAX)
  ) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (bcd_start),
    .bin   (f_val),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (bcd),
    .ovf   (bcd_ovf)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.refresh || pend_q) state_d = START;
      START:   state_d = CONV;
      CONV:    if (!f_dec || bcd_done) state_d = WRITE;
      WRITE:   state_d = last ? COMMIT : CONV;
      COMMIT:  state_d = (pend_q || bus.auto_refresh || bus.refresh)
                         ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Render the current field into a copy of its target shadow row,
  // most significant digit first so blanking can track leading zeros.
  always_comb begin
    src  = f_dec ? DW'(bcd) : hex_q;
    ovf  = f_dec && bcd_ovf;
    wrow = f_row ? sh_b : sh_a;
    lead = f_blk;
    d    = '0;
    ch   = CH_SPACE;
    k    = 0;
    col  = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (i >= int'(f_dig) && src[4*i +: 4] != 4'd0)
        ovf = 1'b1;
    end
    for (int j = 0; j < NDIG; j++) begin
      if (j < int'(f_dig)) begin
        k = int'(f_dig) - 1 - j;
        d = src[4*k +: 4];
        if (d != 4'd0 || k == 0)
          lead = 1'b0;
        ch = ovf ? CH_STAR : (lead ? CH_SPACE : nib2ascii(d));
        col = int'(f_col) + j;
        if (col < ROW_CHARS)
          wrow[8*(ROW_CHARS-1-col) +: 8] = ch;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vals_q  <= '0;
      sh_a    <= ROW_INIT;
      sh_b    <= ROW_INIT;
      row_a_q <= ROW_INIT;
      row_b_q <= ROW_INIT;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      hex_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == COMMIT);
      // a request landing in START still queues: the snapshot is this edge
      if (state_q != IDLE && bus.refresh)
        pend_q <= 1'b1;
      else if (state_q == START)
        pend_q <= 1'b0;
      if (state_q == START) begin
        vals_q <= bus.values;
        sh_a   <= ROW_INIT;
        sh_b   <= ROW_INIT;
        idx_q  <= '0;
      end
      if (state_q == CONV)
        hex_q <= DW'(f_val);
      if (state_q == WRITE) begin
        if (f_row)
          sh_b <= wrow;
        else
          sh_a <= wrow;
        idx_q <= idx_q + IW'(1);
      end
      if (state_q == COMMIT) begin
        row_a_q <= sh_a;
        row_b_q <= sh_b;
      end
    end
  end

  assign bus.row_a      = row_a_q;
  assign bus.row_b      = row_b_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_lcd_field_fmt.sv
// tb_lcd_field_fmt: directed vectors on a default instance and on one with
// a 3-digit decimal field and a hex field running off the row end.
module tb_lcd_field_fmt;
  localparam logic [127:0] INIT = "????????????????";

  logic        clk = 1'b0;
  logic        reset;
  logic        refresh;
  logic        auto_refresh;
  logic [63:0] values;

  always #10 clk = ~clk;

  lcd_field_fmt_if #(.NUM_FIELDS(4), .VAL_W(16), .ROW_CHARS(16)) if1 ();
  lcd_field_fmt_if #(.NUM_FIELDS(4), .VAL_W(16), .ROW_CHARS(16)) if2 ();

  assign if1.refresh      = refresh;
  assign if1.auto_refresh = auto_refresh;
  assign if1.values       = values;
  assign if2.refresh      = refresh;
  assign if2.auto_refresh = auto_refresh;
  assign if2.values       = values;

  lcd_field_fmt dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  lcd_field_fmt #(
    .FIELD_COL ({4'd8, 4'd14, 4'd0, 4'd0}),
    .FIELD_DIG ({3'd3, 3'd4, 3'd2, 3'd2})
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  typedef struct {
    logic [63:0]  vals;
    logic [127:0] a1;
    logic [127:0] b1;
    logic [127:0] a2;
    logic [127:0] b2;
  } vec_t;

  vec_t tv [6];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat, pulses, p, w;

  task automatic chk_row(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got \"%s\" want \"%s\"", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Pulse refresh, return cycles from the sampling edge to frame_done.
  task automatic frame(input logic [63:0] v, input int chg_at,
                       input logic [63:0] v2, output int l);
    @(negedge clk);
    values  = v;
    refresh = 1'b1;
    @(posedge clk);
    #1 refresh = 1'b0;
    l = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (n == chg_at) values = v2;
      if (if1.frame_done) begin
        l = n;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int cycles, output int c);
    c = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      if (if1.frame_done) c++;
    end
  endtask

  initial begin
    reset        = 1'b1;
    refresh      = 1'b0;
    auto_refresh = 1'b0;
    values       = '0;

    tv[0] = '{{16'd42, 16'h1A2B, 16'h0005, 16'h003C},
              "3C??????   42???", "05??????1A2B????",
              "3C?????? 42?????", "05????????????1A"};
    tv[1] = '{64'h0,
              "00??????    0???", "00??????0000????",
              "00??????  0?????", "00????????????00"};
    tv[2] = '{{16'd65535, 16'hFFFF, 16'h00FF, 16'h01A5},
              "**??????65535???", "FF??????FFFF????",
              "**??????***?????", "FF????????????FF"};
    tv[3] = '{{16'd1000, 16'h0009, 16'h0100, 16'h000F},
              "0F?????? 1000???", "**??????0009????",
              "0F??????***?????", "**????????????00"};
    tv[4] = '{{16'd999, 16'hBEEF, 16'h0007, 16'h0099},
              "99??????  999???", "07??????BEEF????",
              "99??????999?????", "07????????????BE"};
    tv[5] = '{{16'd9, 48'h0},
              "00??????    9???", "00??????0000????",
              "00??????  9?????", "00????????????00"};

    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    chk_row("reset_row_a", if1.row_a, INIT);
    chk_row("reset_row_b", if1.row_b, INIT);
    chk_int("reset_busy", int'(if1.busy), 0);
    count_pulses(30, pulses);
    chk_int("idle_no_done", pulses, 0);

    foreach (tv[i]) begin
      frame(tv[i].vals, 0, 64'h0, lat);
      chk_int($sformatf("latency_%0d", i), lat, 25);
      chk_int($sformatf("done2_%0d", i), int'(if2.frame_done), 1);
      chk_int($sformatf("idle_after_%0d", i), int'(if1.busy), 0);
      chk_row($sformatf("row_a_%0d", i), if1.row_a, tv[i].a1);
      chk_row($sformatf("row_b_%0d", i), if1.row_b, tv[i].b1);
      chk_row($sformatf("row_a2_%0d", i), if2.row_a, tv[i].a2);
      chk_row($sformatf("row_b2_%0d", i), if2.row_b, tv[i].b2);
      repeat (2) @(posedge clk);
    end

    // values change after START: frame shows the snapshot
    frame(tv[0].vals, 3, tv[1].vals, lat);
    chk_int("snap_latency", lat, 25);
    chk_row("snap_row_a", if1.row_a, tv[0].a1);
    chk_row("snap_row_b", if1.row_b, tv[0].b1);

    // two mid-frame requests merge into one extra frame
    @(negedge clk);
    values  = tv[3].vals;
    refresh = 1'b1;
    @(negedge clk) refresh = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 90; n++) begin
      @(posedge clk);
      #1;
      refresh = (n == 5 || n == 10);
      if (if1.frame_done) pulses++;
    end
    chk_int("merged_frames", pulses, 2);
    chk_int("merged_idle", int'(if1.busy), 0);
    chk_row("merged_row_a", if1.row_a, tv[3].a1);

    // auto_refresh: back-to-back frames
    @(negedge clk);
    values       = tv[4].vals;
    auto_refresh = 1'b1;
    refresh      = 1'b1;
    @(negedge clk) refresh = 1'b0;
    w = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (if1.frame_done) begin
        w = n;
        break;
      end
    end
    chk_int("auto_first", int'(w > 0), 1);
    p = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (if1.frame_done) begin
        p = n;
        break;
      end
    end
    chk_int("auto_period", p, 25);
    auto_refresh = 1'b0;
    w = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (!if1.busy) begin
        w = n;
        break;
      end
    end
    chk_int("auto_stops", int'(w > 0), 1);
    chk_row("auto_row_a", if1.row_a, tv[4].a1);

    // reset in the middle of a frame
    @(negedge clk);
    values  = tv[0].vals;
    refresh = 1'b1;
    @(posedge clk);
    #1 refresh = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk_row("pre_reset_row_a", if1.row_a, tv[4].a1);
    chk_int("pre_reset_busy", int'(if1.busy), 1);
    reset = 1'b1;
    #1;
    chk_row("midreset_row_a", if1.row_a, INIT);
    chk_row("midreset_row_b", if1.row_b, INIT);
    chk_int("midreset_busy", int'(if1.busy), 0);
    @(negedge clk) reset = 1'b0;
    count_pulses(40, pulses);
    chk_int("midreset_no_done", pulses, 0);
    chk_int("midreset_idle", int'(if1.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
